// File: rtl/frame_lmfc_align_rx_pkg.sv
// rtl/frame_lmfc_align_rx_pkg.sv - shared constants and types for the RX frame/LMFC alignment block
package frame_lmfc_align_rx_pkg;

    // Width of the frames-per-multiframe-minus-1 encoding (1..32 frames).
    localparam int K_W = 5;

    // 8b/10b control characters, valid only when the octet is flagged as K.
    localparam logic [7:0] K_R = 8'h1C;
    localparam logic [7:0] K_A = 8'h7C;
    localparam logic [7:0] K_F = 8'hFC;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ILAS = 2'd1,
        ILAS      = 2'd2,
        DATA      = 2'd3
    } state_e;

endpackage

// File: rtl/frame_lmfc_align_rx_frame_pos_counter.sv
// rtl/frame_lmfc_align_rx_frame_pos_counter.sv - octet/frame position counter with load and wrap at K
//
// Two octets per frame; frame index wraps from i_k back to 0.
// Priority: i_clear > i_load > i_advance.
//   i_k          frames per multiframe minus 1
//   i_clear      force position to (0,0)
//   i_load       set position of the next octet to (i_load_octet, i_load_frame)
//   i_advance    step to the next octet position
//   o_octet_pos  octet index of the octet currently presented
//   o_frame_pos  frame index of the octet currently presented
//   o_next_frame frame index that follows the current one (wrapped)
//   o_mf_last    current octet is the last octet of the multiframe
module frame_pos_counter
    import frame_lmfc_align_rx_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [K_W-1:0] i_k,
    input  logic           i_clear,
    input  logic           i_load,
    input  logic           i_load_octet,
    input  logic [K_W-1:0] i_load_frame,
    input  logic           i_advance,
    output logic           o_octet_pos,
    output logic [K_W-1:0] o_frame_pos,
    output logic [K_W-1:0] o_next_frame,
    output logic           o_mf_last
);

    logic           octet_pos_q;
    logic           octet_pos_d;
    logic [K_W-1:0] frame_pos_q;
    logic [K_W-1:0] frame_pos_d;
    logic [K_W-1:0] next_frame;

    always_comb begin
        next_frame  = (frame_pos_q == i_k) ? '0 : frame_pos_q + K_W'(1);
        octet_pos_d = octet_pos_q;
        frame_pos_d = frame_pos_q;
        if (i_clear) begin
            octet_pos_d = 1'b0;
            frame_pos_d = '0;
        end else if (i_load) begin
            octet_pos_d = i_load_octet;
            frame_pos_d = i_load_frame;
        end else if (i_advance) begin
            octet_pos_d = ~octet_pos_q;
            if (octet_pos_q) begin
                frame_pos_d = next_frame;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            octet_pos_q <= 1'b0;
            frame_pos_q <= '0;
        end else begin
            octet_pos_q <= octet_pos_d;
            frame_pos_q <= frame_pos_d;
        end
    end

    assign o_octet_pos  = octet_pos_q;
    assign o_frame_pos  = frame_pos_q;
    assign o_next_frame = next_frame;
    assign o_mf_last    = octet_pos_q && (frame_pos_q == i_k);

endmodule

// File: rtl/frame_lmfc_align_rx.sv
// rtl/frame_lmfc_align_rx.sv - receive-side octet/frame/multiframe phase lock and monitor
//
// Locks phase on the ILAS /R/, checks /A/ at each ILAS multiframe end, then
// watches /A/ and /F/ placement in user data and realigns after ERR_THRESH
// consecutive misplacements at the same offset. F = 2 octets per frame.
//   clk, rst       device clock, asynchronous active-high reset
//   i_K            frames per multiframe minus 1
//   i_cgs_done     code group sync achieved; low forces IDLE
//   i_valid        i_data/i_is_k carry an octet
//   i_data,i_is_k  decoded octet and control flag
//   o_frame_clk    pulse the cycle after the first octet of a frame
//   o_lmfc_clk     pulse the cycle after the first octet of a multiframe
//   o_octet_pos    octet index of the octet presented this cycle
//   o_frame_pos    frame index of the octet presented this cycle
//   o_ilas_active  ILAS in progress
//   o_aligned      locked, user data phase
//   o_align_err    pulse on any alignment fault
//   o_realign      pulse when the phase is moved in user data
module frame_lmfc_align_rx
    import frame_lmfc_align_rx_pkg::*;
#(
    parameter int ERR_THRESH = 3,
    parameter int ILAS_MF    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [K_W-1:0] i_K,
    input  logic           i_cgs_done,
    input  logic           i_valid,
    input  logic [7:0]     i_data,
    input  logic           i_is_k,
    output logic           o_frame_clk,
    output logic           o_lmfc_clk,
    output logic           o_octet_pos,
    output logic [K_W-1:0] o_frame_pos,
    output logic           o_ilas_active,
    output logic           o_aligned,
    output logic           o_align_err,
    output logic           o_realign
);

    localparam int MF_W = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;

    state_e            state_q, state_d;
    logic [MF_W-1:0]   mf_cnt_q, mf_cnt_d;
    logic [2:0]        err_cnt_q, err_cnt_d;
    logic              err_is_a_q, err_is_a_d;
    logic              err_oct_q, err_oct_d;
    logic [K_W-1:0]    err_frm_q, err_frm_d;
    logic              frame_clk_q, frame_clk_d;
    logic              lmfc_clk_q, lmfc_clk_d;
    logic              align_err_q, align_err_d;
    logic              realign_q, realign_d;

    logic              ctr_clear, ctr_load, ctr_advance;
    logic              load_octet;
    logic [K_W-1:0]    load_frame;
    logic              octet_pos;
    logic [K_W-1:0]    frame_pos;
    logic [K_W-1:0]    next_frame;
    logic              mf_last;

    logic              is_r, is_a, is_f;
    logic              same_pos;
    logic [2:0]        cnt_next;

    frame_pos_counter u_pos (
        .clk          (clk),
        .rst          (rst),
        .i_k          (i_K),
        .i_clear      (ctr_clear),
        .i_load       (ctr_load),
        .i_load_octet (load_octet),
        .i_load_frame (load_frame),
        .i_advance    (ctr_advance),
        .o_octet_pos  (octet_pos),
        .o_frame_pos  (frame_pos),
        .o_next_frame (next_frame),
        .o_mf_last    (mf_last)
    );

    assign is_r = i_valid && i_is_k && (i_data == K_R);
    assign is_a = i_valid && i_is_k && (i_data == K_A);
    assign is_f = i_valid && i_is_k && (i_data == K_F);

    // A misplaced character repeats the previous one when it is the same kind
    // at the same offset; /F/ offset is within the frame, /A/ within the multiframe.
    assign same_pos = (err_cnt_q != 3'd0) && (err_is_a_q == is_a) &&
                      (err_oct_q == octet_pos) && (!is_a || (err_frm_q == frame_pos));
    assign cnt_next = same_pos ? err_cnt_q + 3'd1 : 3'd1;

    always_comb begin
        state_d     = state_q;
        mf_cnt_d    = mf_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_is_a_d  = err_is_a_q;
        err_oct_d   = err_oct_q;
        err_frm_d   = err_frm_q;
        align_err_d = 1'b0;
        realign_d   = 1'b0;
        ctr_clear   = 1'b0;
        ctr_load    = 1'b0;
        ctr_advance = 1'b0;
        load_octet  = 1'b0;
        load_frame  = '0;

        case (state_q)
            IDLE: begin
                ctr_clear = 1'b1;
                mf_cnt_d  = '0;
                err_cnt_d = 3'd0;
                if (i_cgs_done) begin
                    state_d = WAIT_ILAS;
                end
            end

            WAIT_ILAS: begin
                mf_cnt_d = '0;
                // Counters sit at (0,0) so the /R/ octet is position 0; stepping
                // past it makes the next octet position 1.
                if (is_r) begin
                    ctr_advance = 1'b1;
                    state_d     = ILAS;
                end else begin
                    ctr_clear = 1'b1;
                end
            end

            ILAS: begin
                ctr_advance = i_valid;
                if (i_valid && mf_last) begin
                    if (!is_a) begin
                        align_err_d = 1'b1;
                        state_d     = WAIT_ILAS;
                        ctr_clear   = 1'b1;
                        ctr_advance = 1'b0;
                        mf_cnt_d    = '0;
                    end else if (mf_cnt_q == MF_W'(ILAS_MF - 1)) begin
                        state_d   = DATA;
                        mf_cnt_d  = '0;
                        err_cnt_d = 3'd0;
                    end else begin
                        mf_cnt_d = mf_cnt_q + MF_W'(1);
                    end
                end
            end

            DATA: begin
                ctr_advance = i_valid;
                if (is_a || is_f) begin
                    if ((is_a && mf_last) || (is_f && octet_pos)) begin
                        err_cnt_d = 3'd0;
                    end else begin
                        align_err_d = 1'b1;
                        err_is_a_d  = is_a;
                        err_oct_d   = octet_pos;
                        err_frm_d   = frame_pos;
                        if (cnt_next >= 3'(ERR_THRESH)) begin
                            // This octet becomes the last of its multiframe (/A/)
                            // or of its frame (/F/), so the next octet starts
                            // a new multiframe or the following frame.
                            realign_d   = 1'b1;
                            err_cnt_d   = 3'd0;
                            ctr_load    = 1'b1;
                            load_octet  = 1'b0;
                            load_frame  = is_a ? '0 : next_frame;
                        end else begin
                            err_cnt_d = cnt_next;
                        end
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                ctr_clear = 1'b1;
            end
        endcase

        // Losing code group sync overrides every check in every state.
        if (!i_cgs_done) begin
            state_d     = IDLE;
            ctr_clear   = 1'b1;
            ctr_load    = 1'b0;
            ctr_advance = 1'b0;
            mf_cnt_d    = '0;
            err_cnt_d   = 3'd0;
            align_err_d = 1'b0;
            realign_d   = 1'b0;
        end

        frame_clk_d = i_valid && !octet_pos && ((state_d == ILAS) || (state_d == DATA));
        lmfc_clk_d  = frame_clk_d && (frame_pos == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mf_cnt_q    <= '0;
            err_cnt_q   <= 3'd0;
            err_is_a_q  <= 1'b0;
            err_oct_q   <= 1'b0;
            err_frm_q   <= '0;
            frame_clk_q <= 1'b0;
            lmfc_clk_q  <= 1'b0;
            align_err_q <= 1'b0;
            realign_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mf_cnt_q    <= mf_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_is_a_q  <= err_is_a_d;
            err_oct_q   <= err_oct_d;
            err_frm_q   <= err_frm_d;
            frame_clk_q <= frame_clk_d;
            lmfc_clk_q  <= lmfc_clk_d;
            align_err_q <= align_err_d;
            realign_q   <= realign_d;
        end
    end

    assign o_frame_clk   = frame_clk_q;
    assign o_lmfc_clk    = lmfc_clk_q;
    assign o_octet_pos   = octet_pos;
    assign o_frame_pos   = frame_pos;
    assign o_ilas_active = (state_q == ILAS);
    assign o_aligned     = (state_q == DATA);
    assign o_align_err   = align_err_q;
    assign o_realign     = realign_q;

endmodule

// File: tb/tb_frame_lmfc_align_rx.sv
// tb/tb_frame_lmfc_align_rx.sv - directed self-checking bench for frame_lmfc_align_rx
module tb_frame_lmfc_align_rx;

    localparam logic [7:0] C_R = 8'h1C;
    localparam logic [7:0] C_A = 8'h7C;
    localparam logic [7:0] C_F = 8'hFC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] i_K = 5'd0;
    logic       i_cgs_done = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'd0;
    logic       i_is_k = 1'b0;

    logic       o_frame_clk, o_lmfc_clk, o_octet_pos, o_ilas_active;
    logic       o_aligned, o_align_err, o_realign;
    logic [4:0] o_frame_pos;

    int errors = 0;
    int checks = 0;

    // Position of the octet presented (before the edge) and registered
    // outputs produced by it (after the edge).
    logic       s_oct;
    logic [4:0] s_frm;
    logic       s_fclk, s_lclk, s_ilas, s_aligned, s_err, s_realign;

    always #5 clk = ~clk;

    frame_lmfc_align_rx dut (
        .clk           (clk),
        .rst           (rst),
        .i_K           (i_K),
        .i_cgs_done    (i_cgs_done),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_is_k        (i_is_k),
        .o_frame_clk   (o_frame_clk),
        .o_lmfc_clk    (o_lmfc_clk),
        .o_octet_pos   (o_octet_pos),
        .o_frame_pos   (o_frame_pos),
        .o_ilas_active (o_ilas_active),
        .o_aligned     (o_aligned),
        .o_align_err   (o_align_err),
        .o_realign     (o_realign)
    );

    task automatic step(input logic v, input logic [7:0] d, input logic k);
        i_valid = v;
        i_data  = d;
        i_is_k  = k;
        #1;
        s_oct = o_octet_pos;
        s_frm = o_frame_pos;
        @(posedge clk);
        #1;
        s_fclk    = o_frame_clk;
        s_lclk    = o_lmfc_clk;
        s_ilas    = o_ilas_active;
        s_aligned = o_aligned;
        s_err     = o_align_err;
        s_realign = o_realign;
    endtask

    task automatic send(input logic [7:0] d, input logic k);
        step(1'b1, d, k);
    endtask

    // Drop sync, set K, then run /R/ plus four ILAS multiframes ending in /A/.
    task automatic do_lock(input logic [4:0] kk);
        int mf_len;
        i_cgs_done = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        i_K = kk;
        i_cgs_done = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        mf_len = 2 * (int'(kk) + 1);
        for (int i = 0; i < 4 * mf_len; i++) begin
            if (i == 0) send(C_R, 1'b1);
            else if (i % mf_len == mf_len - 1) send(C_A, 1'b1);
            else send(8'(i), 1'b0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_frame_clk !== 1'b0) begin errors++; $display("FAIL reset_frame_clk got %b want 0", o_frame_clk); end
        checks++; if (o_lmfc_clk !== 1'b0) begin errors++; $display("FAIL reset_lmfc_clk got %b want 0", o_lmfc_clk); end
        checks++; if (o_octet_pos !== 1'b0) begin errors++; $display("FAIL reset_octet_pos got %b want 0", o_octet_pos); end
        checks++; if (o_frame_pos !== 5'd0) begin errors++; $display("FAIL reset_frame_pos got %0d want 0", o_frame_pos); end
        checks++; if (o_ilas_active !== 1'b0) begin errors++; $display("FAIL reset_ilas_active got %b want 0", o_ilas_active); end
        checks++; if (o_aligned !== 1'b0) begin errors++; $display("FAIL reset_aligned got %b want 0", o_aligned); end
        checks++; if (o_align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err got %b want 0", o_align_err); end
        checks++; if (o_realign !== 1'b0) begin errors++; $display("FAIL reset_realign got %b want 0", o_realign); end
        rst = 1'b0;
    endtask

    task automatic test_ilas_lock();
        int ilas_cycles;
        i_K = 5'd3;
        i_cgs_done = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        ilas_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) send(C_R, 1'b1);
            else if (i < 32 && i % 8 == 7) send(C_A, 1'b1);
            else send(8'(i), 1'b0);
            if (s_ilas) ilas_cycles++;
            checks++; if (s_oct !== 1'(i % 2)) begin errors++; $display("FAIL ilas_octet_pos[%0d] got %b want %0d", i, s_oct, i % 2); end
            checks++; if (s_frm !== 5'((i / 2) % 4)) begin errors++; $display("FAIL ilas_frame_pos[%0d] got %0d want %0d", i, s_frm, (i / 2) % 4); end
            checks++; if (s_lclk !== (i % 8 == 0)) begin errors++; $display("FAIL ilas_lmfc_clk[%0d] got %b want %b", i, s_lclk, (i % 8 == 0)); end
            checks++; if (s_fclk !== (i % 2 == 0)) begin errors++; $display("FAIL ilas_frame_clk[%0d] got %b want %b", i, s_fclk, (i % 2 == 0)); end
            checks++; if (s_aligned !== (i >= 31)) begin errors++; $display("FAIL ilas_aligned[%0d] got %b want %b", i, s_aligned, (i >= 31)); end
            checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL ilas_align_err[%0d] got %b want 0", i, s_err); end
        end
        checks++; if (ilas_cycles != 31) begin errors++; $display("FAIL ilas_active_cycles got %0d want 31", ilas_cycles); end
    endtask

    task automatic test_ilas_bad_a();
        i_cgs_done = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        i_K = 5'd3;
        i_cgs_done = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 23; i++) begin
            if (i == 0) send(C_R, 1'b1);
            else if (i % 8 == 7) send(C_A, 1'b1);
            else send(8'(i), 1'b0);
        end
        checks++; if (s_ilas !== 1'b1) begin errors++; $display("FAIL bad_a_pre_ilas got %b want 1", s_ilas); end
        send(8'h55, 1'b0);
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL bad_a_err got %b want 1", s_err); end
        checks++; if (s_ilas !== 1'b0) begin errors++; $display("FAIL bad_a_ilas got %b want 0", s_ilas); end
        checks++; if (s_aligned !== 1'b0) begin errors++; $display("FAIL bad_a_aligned got %b want 0", s_aligned); end
        send(C_A, 1'b1);
        checks++; if (s_oct !== 1'b0 || s_frm !== 5'd0) begin errors++; $display("FAIL bad_a_pos_cleared got %b/%0d want 0/0", s_oct, s_frm); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL bad_a_err_single got %b want 0", s_err); end
        checks++; if (s_ilas !== 1'b0) begin errors++; $display("FAIL bad_a_needs_r got %b want 0", s_ilas); end
    endtask

    task automatic test_realign_a();
        do_lock(5'd1);
        checks++; if (s_aligned !== 1'b1) begin errors++; $display("FAIL realign_locked got %b want 1", s_aligned); end
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(C_A, 1'b1);
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL realign_good_a_err got %b want 0", s_err); end
        for (int m = 1; m <= 3; m++) begin
            send(8'h10, 1'b0);
            send(C_A, 1'b1);
            checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL realign_err_mf%0d got %b want 1", m, s_err); end
            checks++; if (s_realign !== (m == 3)) begin errors++; $display("FAIL realign_pulse_mf%0d got %b want %b", m, s_realign, (m == 3)); end
            checks++; if (s_aligned !== 1'b1) begin errors++; $display("FAIL realign_aligned_mf%0d got %b want 1", m, s_aligned); end
            if (m < 3) begin
                send(8'h12, 1'b0);
                checks++; if (s_lclk !== 1'b0) begin errors++; $display("FAIL realign_old_lmfc_mf%0d got %b want 0", m, s_lclk); end
                send(8'h13, 1'b0);
            end
        end
        send(8'h20, 1'b0);
        checks++; if (s_oct !== 1'b0 || s_frm !== 5'd0) begin errors++; $display("FAIL realign_new_pos got %b/%0d want 0/0", s_oct, s_frm); end
        checks++; if (s_lclk !== 1'b1) begin errors++; $display("FAIL realign_early_lmfc got %b want 1", s_lclk); end
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        checks++; if (s_lclk !== 1'b0 || s_fclk !== 1'b1) begin errors++; $display("FAIL realign_frame1 got lmfc=%b frame=%b want 0/1", s_lclk, s_fclk); end
        send(C_A, 1'b1);
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL realign_new_a_ok got %b want 0", s_err); end
    endtask

    // Continues in DATA with i_K=1 at a multiframe boundary.
    task automatic test_f_clear();
        logic saw_realign;
        saw_realign = 1'b0;
        send(C_F, 1'b1);
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL fclr_mis1 got %b want 1", s_err); end
        send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b0);
        send(C_F, 1'b1);
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL fclr_mis2 got %b want 1", s_err); end
        saw_realign = saw_realign | s_realign;
        send(C_F, 1'b1);
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL fclr_good_f got %b want 0", s_err); end
        send(8'h34, 1'b0); send(8'h35, 1'b0);
        for (int m = 0; m < 2; m++) begin
            send(C_F, 1'b1);
            checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL fclr_after_clear%0d got %b want 1", m, s_err); end
            saw_realign = saw_realign | s_realign;
            send(8'h36, 1'b0); send(8'h37, 1'b0); send(8'h38, 1'b0);
            saw_realign = saw_realign | s_realign;
        end
        checks++; if (saw_realign !== 1'b0) begin errors++; $display("FAIL fclr_no_realign got %b want 0", saw_realign); end
        checks++; if (s_aligned !== 1'b1) begin errors++; $display("FAIL fclr_aligned got %b want 1", s_aligned); end
    endtask

    task automatic test_valid_toggle();
        int n;
        do_lock(5'd0);
        checks++; if (s_aligned !== 1'b1) begin errors++; $display("FAIL vt_locked got %b want 1", s_aligned); end
        n = 0;
        for (int j = 0; j < 10; j++) begin
            if (j % 2 == 0) step(1'b1, 8'(8'h40 + j), 1'b0);
            else step(1'b0, C_A, 1'b1);
            checks++; if (s_oct !== 1'(n % 2) || s_frm !== 5'd0) begin errors++; $display("FAIL vt_pos[%0d] got %b/%0d want %0d/0", j, s_oct, s_frm, n % 2); end
            checks++; if (s_fclk !== (j % 2 == 0 && n % 2 == 0)) begin errors++; $display("FAIL vt_frame_clk[%0d] got %b want %b", j, s_fclk, (j % 2 == 0 && n % 2 == 0)); end
            checks++; if (s_lclk !== s_fclk) begin errors++; $display("FAIL vt_lmfc_clk[%0d] got %b want %b", j, s_lclk, s_fclk); end
            checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL vt_err[%0d] got %b want 0", j, s_err); end
            if (j % 2 == 0) n++;
        end
    endtask

    task automatic test_cgs_drop();
        i_cgs_done = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        i_K = 5'd3;
        i_cgs_done = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        send(C_R, 1'b1);
        for (int i = 1; i < 6; i++) send(8'(i), 1'b0);
        checks++; if (s_ilas !== 1'b1) begin errors++; $display("FAIL cgs_pre_ilas got %b want 1", s_ilas); end
        i_cgs_done = 1'b0;
        send(8'h06, 1'b0);
        checks++; if (s_ilas !== 1'b0 || s_aligned !== 1'b0) begin errors++; $display("FAIL cgs_drop_state got ilas=%b al=%b want 0/0", s_ilas, s_aligned); end
        checks++; if (s_fclk !== 1'b0 || s_lclk !== 1'b0) begin errors++; $display("FAIL cgs_drop_clk got %b/%b want 0/0", s_fclk, s_lclk); end
        i_cgs_done = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        checks++; if (s_oct !== 1'b0 || s_frm !== 5'd0) begin errors++; $display("FAIL cgs_drop_pos got %b/%0d want 0/0", s_oct, s_frm); end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) send(C_A, 1'b1);
            else send(8'(8'h50 + i), 1'b0);
            checks++; if (s_ilas !== 1'b0 || s_fclk !== 1'b0) begin errors++; $display("FAIL cgs_no_relock[%0d] got ilas=%b fclk=%b want 0/0", i, s_ilas, s_fclk); end
        end
        send(C_R, 1'b1);
        checks++; if (s_ilas !== 1'b1 || s_lclk !== 1'b1) begin errors++; $display("FAIL cgs_relock_r got ilas=%b lmfc=%b want 1/1", s_ilas, s_lclk); end
    endtask

    task automatic test_async_rst();
        do_lock(5'd1);
        send(8'h60, 1'b0); send(8'h61, 1'b0); send(8'h62, 1'b0);
        checks++; if (o_aligned !== 1'b1 || o_octet_pos !== 1'b1 || o_frame_pos !== 5'd1) begin errors++; $display("FAIL arst_pre got al=%b pos=%b/%0d want 1 1/1", o_aligned, o_octet_pos, o_frame_pos); end
        rst = 1'b1;
        #2;
        checks++; if (o_aligned !== 1'b0 || o_ilas_active !== 1'b0) begin errors++; $display("FAIL arst_state got al=%b ilas=%b want 0/0", o_aligned, o_ilas_active); end
        checks++; if (o_octet_pos !== 1'b0 || o_frame_pos !== 5'd0) begin errors++; $display("FAIL arst_pos got %b/%0d want 0/0", o_octet_pos, o_frame_pos); end
        checks++; if (o_frame_clk !== 1'b0 || o_lmfc_clk !== 1'b0 || o_align_err !== 1'b0 || o_realign !== 1'b0) begin errors++; $display("FAIL arst_pulses got %b%b%b%b want 0000", o_frame_clk, o_lmfc_clk, o_align_err, o_realign); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) send(C_A, 1'b1);
            else send(8'(8'h70 + i), 1'b0);
        end
        checks++; if (s_aligned !== 1'b0 || s_ilas !== 1'b0) begin errors++; $display("FAIL arst_no_relock got al=%b ilas=%b want 0/0", s_aligned, s_ilas); end
        send(C_R, 1'b1);
        checks++; if (s_ilas !== 1'b1) begin errors++; $display("FAIL arst_relock_r got %b want 1", s_ilas); end
    endtask

    initial begin
        test_reset();
        test_ilas_lock();
        test_ilas_bad_a();
        test_realign_a();
        test_f_clear();
        test_valid_toggle();
        test_cgs_drop();
        test_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
